// File: rtl/rx_block_pkg.sv
// rtl/rx_block_pkg.sv - shared types and constants for the RX 128b/130b block aligner
package rx_block_pkg;

    typedef enum logic [1:0] {
        UNALIGNED = 2'd0,
        ALIGNED   = 2'd1,
        LOCKED    = 2'd2
    } align_state_t;

    localparam logic [1:0]  SH_DATA         = 2'b01;
    localparam logic [1:0]  SH_OS           = 2'b10;
    localparam logic [31:0] EIEOS_BEAT      = 32'hFF00FF00;
    localparam int          BEATS_PER_BLOCK = 4;

    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_OS);
    endfunction

endpackage

// File: rtl/rx_eieos_detector.sv
// rtl/rx_eieos_detector.sv - EIEOS search: counts matching beats from a candidate block start
module rx_eieos_detector
    import rx_block_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        en_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  sh_i,
    output logic        found_o
);

    logic [2:0] match_cnt_q, match_cnt_d;
    logic       is_eieos, is_cand;

    assign is_eieos = (data_i == EIEOS_BEAT);
    assign is_cand  = is_eieos && (sh_i == SH_OS);

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) match_cnt_q <= '0;
        else        match_cnt_q <= match_cnt_d;
    end

    always_comb begin
        match_cnt_d = match_cnt_q;
        found_o     = 1'b0;
        if (!en_i) begin
            match_cnt_d = '0;
        end else if (valid_i) begin
            if (match_cnt_q == 3'd0) begin
                match_cnt_d = is_cand ? 3'd1 : 3'd0;
            end else if (is_eieos) begin
                // The last beat of the EIEOS block completes alignment and rearms the search
                if (match_cnt_q == 3'(BEATS_PER_BLOCK - 1)) begin
                    found_o     = 1'b1;
                    match_cnt_d = '0;
                end else begin
                    match_cnt_d = match_cnt_q + 3'd1;
                end
            end else begin
                match_cnt_d = is_cand ? 3'd1 : 3'd0;
            end
        end
    end

endmodule

// File: rtl/rx_block_align_ctrl.sv
// rtl/rx_block_align_ctrl.sv - per-lane RX block alignment, beat sequencing and sync-header monitor
module rx_block_align_ctrl
    import rx_block_pkg::*;
#(
    parameter int ERR_THRESH  = 4,
    parameter int LOCK_BLOCKS = 8
) (
    input  logic        CLK,
    input  logic        RST_L,
    input  logic        RX_Valid,
    input  logic [31:0] RX_Data,
    input  logic [0:1]  RX_Sync_Header,
    input  logic        Realign_Req,
    output logic [31:0] RX_Data_Out,
    output logic        RX_Data_Valid_Out,
    output logic        RX_Start_Block,
    output logic [1:0]  RX_Beat_Idx,
    output logic        Block_Type,
    output logic        Sync_Err,
    output logic        Aligned,
    output logic        Locked
);

    align_state_t state_q, state_d;
    logic [1:0]   beat_cnt_q, beat_cnt_d;
    logic [3:0]   good_cnt_q, good_cnt_d;
    logic [3:0]   bad_cnt_q, bad_cnt_d;
    logic [31:0]  data_q;
    logic         dvalid_q, dvalid_d;
    logic         start_q, start_d;
    logic [1:0]   idx_q, idx_d;
    logic         btype_q, btype_d;
    logic         serr_q, serr_d;
    logic         found, is_aligned, hdr_ok;

    assign is_aligned = (state_q != UNALIGNED);
    assign hdr_ok     = sh_valid(RX_Sync_Header);

    rx_eieos_detector u_eieos (
        .CLK     (CLK),
        .RST_L   (RST_L),
        .en_i    ((state_q == UNALIGNED) && !Realign_Req),
        .valid_i (RX_Valid),
        .data_i  (RX_Data),
        .sh_i    (RX_Sync_Header),
        .found_o (found)
    );

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q    <= UNALIGNED;
            beat_cnt_q <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            data_q     <= '0;
            dvalid_q   <= 1'b0;
            start_q    <= 1'b0;
            idx_q      <= '0;
            btype_q    <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            data_q     <= RX_Data;
            dvalid_q   <= dvalid_d;
            start_q    <= start_d;
            idx_q      <= idx_d;
            btype_q    <= btype_d;
            serr_q     <= serr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (Realign_Req) begin
            state_d    = UNALIGNED;
            beat_cnt_d = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (state_q == UNALIGNED) begin
            if (found) begin
                state_d    = ALIGNED;
                beat_cnt_d = '0;
            end
        end else if (RX_Valid) begin
            beat_cnt_d = beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd0) begin
                if (hdr_ok) begin
                    bad_cnt_d = '0;
                    if (good_cnt_q < 4'(LOCK_BLOCKS)) good_cnt_d = good_cnt_q + 4'd1;
                    if ((state_q == ALIGNED) && (good_cnt_d == 4'(LOCK_BLOCKS))) state_d = LOCKED;
                end else begin
                    good_cnt_d = '0;
                    bad_cnt_d  = bad_cnt_q + 4'd1;
                    if (bad_cnt_d == 4'(ERR_THRESH)) begin
                        state_d    = UNALIGNED;
                        beat_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end
                end
            end
        end
    end

    // The beat presented alongside Realign_Req is already dropped from the aligned stream
    always_comb begin
        dvalid_d = RX_Valid && is_aligned && !Realign_Req;
        start_d  = dvalid_d && (beat_cnt_q == 2'd0);
        idx_d    = dvalid_d ? beat_cnt_q : idx_q;
        btype_d  = start_d ? (RX_Sync_Header == SH_OS) : btype_q;
        serr_d   = start_d && !hdr_ok;
    end

    assign RX_Data_Out       = data_q;
    assign RX_Data_Valid_Out = dvalid_q;
    assign RX_Start_Block    = start_q;
    assign RX_Beat_Idx       = idx_q;
    assign Block_Type        = btype_q;
    assign Sync_Err          = serr_q;
    assign Aligned           = is_aligned;
    assign Locked            = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_block_align_ctrl.sv
// tb/tb_rx_block_align_ctrl.sv - self-checking bench for rx_block_align_ctrl
module tb_rx_block_align_ctrl;

    localparam int          ERR_T  = 4;
    localparam int          LOCK_B = 8;
    localparam logic [31:0] EIE    = 32'hFF00FF00;

    logic        CLK, RST_L;
    logic        RX_Valid, Realign_Req;
    logic [31:0] RX_Data;
    logic [0:1]  RX_Sync_Header;
    logic [31:0] RX_Data_Out;
    logic        RX_Data_Valid_Out, RX_Start_Block, Block_Type, Sync_Err, Aligned, Locked;
    logic [1:0]  RX_Beat_Idx;

    rx_block_align_ctrl #(.ERR_THRESH(ERR_T), .LOCK_BLOCKS(LOCK_B)) dut (
        .CLK               (CLK),
        .RST_L             (RST_L),
        .RX_Valid          (RX_Valid),
        .RX_Data           (RX_Data),
        .RX_Sync_Header    (RX_Sync_Header),
        .Realign_Req       (Realign_Req),
        .RX_Data_Out       (RX_Data_Out),
        .RX_Data_Valid_Out (RX_Data_Valid_Out),
        .RX_Start_Block    (RX_Start_Block),
        .RX_Beat_Idx       (RX_Beat_Idx),
        .Block_Type        (Block_Type),
        .Sync_Err          (Sync_Err),
        .Aligned           (Aligned),
        .Locked            (Locked)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: alignment found from a sliding window of the last four valid beats,
    // block position from a running count of aligned beats, health from header streaks.
    bit          m_aligned, m_locked;
    int          m_nbeats, m_good_run, m_bad_run;
    logic [33:0] win[$];
    logic [31:0] e_data;
    logic        e_dv, e_start, e_bt, e_serr;
    logic [1:0]  e_idx;

    task automatic model_reset();
        m_aligned = 0; m_locked = 0; m_nbeats = 0; m_good_run = 0; m_bad_run = 0;
        win.delete();
        e_data = '0; e_dv = 0; e_start = 0; e_bt = 0; e_serr = 0; e_idx = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input logic [1:0] sh, input bit rr);
        bit ok, all_eie;
        e_data = d; e_dv = 0; e_start = 0; e_serr = 0;
        if (rr) begin
            m_aligned = 0; m_locked = 0;
            win.delete();
        end else if (!m_aligned) begin
            if (v) begin
                win.push_back({sh, d});
                if (win.size() > 4) void'(win.pop_front());
                all_eie = (win.size() == 4);
                foreach (win[i]) if (win[i][31:0] != EIE) all_eie = 0;
                if (all_eie && win[0][33:32] == 2'b10) begin
                    m_aligned = 1; m_nbeats = 0; m_good_run = 0; m_bad_run = 0;
                    win.delete();
                end
            end
        end else if (v) begin
            e_dv    = 1;
            e_idx   = 2'(m_nbeats % 4);
            e_start = (m_nbeats % 4 == 0);
            if (e_start) begin
                ok     = (sh == 2'b01) || (sh == 2'b10);
                e_bt   = (sh == 2'b10);
                e_serr = !ok;
                if (ok) begin
                    m_good_run++; m_bad_run = 0;
                    if (m_good_run >= LOCK_B) m_locked = 1;
                end else begin
                    m_bad_run++; m_good_run = 0;
                    if (m_bad_run == ERR_T) begin
                        m_aligned = 0; m_locked = 0;
                        win.delete();
                    end
                end
            end
            m_nbeats++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ":data"},    RX_Data_Out,       e_data);
        chk({tag, ":dvalid"},  RX_Data_Valid_Out, e_dv);
        chk({tag, ":start"},   RX_Start_Block,    e_start);
        chk({tag, ":idx"},     RX_Beat_Idx,       e_idx);
        chk({tag, ":btype"},   Block_Type,        e_bt);
        chk({tag, ":syncerr"}, Sync_Err,          e_serr);
        chk({tag, ":aligned"}, Aligned,           m_aligned);
        chk({tag, ":locked"},  Locked,            m_locked);
    endtask

    task automatic step(input string tag, input bit v, input logic [31:0] d,
                        input logic [1:0] sh, input bit rr);
        RX_Valid = v; RX_Data = d; RX_Sync_Header = sh; Realign_Req = rr;
        model_step(v, d, sh, rr);
        @(posedge CLK); #1;
        compare_all(tag);
    endtask

    task automatic eieos(input string tag);
        step(tag, 1, EIE, 2'b10, 0);
        for (int i = 0; i < 3; i++) step(tag, 1, EIE, 2'($urandom), 0);
    endtask

    task automatic block(input string tag, input logic [1:0] sh, input bit gaps);
        for (int b = 0; b < 4; b++) begin
            if (gaps && b % 2 == 1) step(tag, 0, $urandom, 2'($urandom), 0);
            step(tag, 1, $urandom, (b == 0) ? sh : 2'($urandom), 0);
        end
    endtask

    initial begin
        RST_L = 0; RX_Valid = 0; RX_Data = '0; RX_Sync_Header = 2'b00; Realign_Req = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare_all("reset");
        RST_L = 1;

        // 1: EIEOS aligns, next valid beat starts a block
        eieos("t1_eieos");
        chk("t1_aligned", Aligned, 1'b1);
        step("t1_b0", 1, $urandom, 2'b01, 0);
        chk("t1_start", RX_Start_Block, 1'b1);
        chk("t1_idx0", RX_Beat_Idx, 2'd0);
        for (int i = 0; i < 3; i++) step("t1_b", 1, $urandom, 2'b01, 0);

        // 2: data block then OS block with gaps
        block("t2_data", 2'b01, 1);
        chk("t2_bt0", Block_Type, 1'b0);
        block("t2_os", 2'b10, 1);
        chk("t2_bt1", Block_Type, 1'b1);

        // 3: lock on the 8th consecutive good block
        for (int k = 0; k < 4; k++) block("t3_blk", 2'($urandom_range(1, 2)), 0);
        chk("t3_not_locked", Locked, 1'b0);
        step("t3_b0", 1, $urandom, 2'b01, 0);
        chk("t3_locked", Locked, 1'b1);
        for (int i = 0; i < 3; i++) step("t3_b", 1, $urandom, 2'b01, 0);

        // 4: isolated bad headers keep lock, four in a row drop alignment
        block("t4_bad", 2'b11, 0);
        block("t4_bad", 2'b00, 0);
        block("t4_bad", 2'b11, 0);
        block("t4_good", 2'b01, 0);
        chk("t4_still_locked", Locked, 1'b1);
        block("t4_bad", 2'b11, 0);
        block("t4_bad", 2'b00, 0);
        block("t4_bad", 2'b11, 0);
        step("t4_last", 1, $urandom, 2'b00, 0);
        chk("t4_serr", Sync_Err, 1'b1);
        chk("t4_dropped", Aligned, 1'b0);
        for (int i = 0; i < 3; i++) step("t4_tail", 1, $urandom, 2'b01, 0);
        chk("t4_dv_off", RX_Data_Valid_Out, 1'b0);

        // 5: partial EIEOS does not align, full one does
        step("t5_p", 1, EIE, 2'b10, 0);
        step("t5_p", 1, EIE, 2'b01, 0);
        step("t5_p", 1, EIE, 2'b01, 0);
        step("t5_p", 1, 32'h0, 2'b01, 0);
        step("t5_p", 1, EIE, 2'b00, 0);
        chk("t5_unaligned", Aligned, 1'b0);
        eieos("t5_full");
        chk("t5_aligned", Aligned, 1'b1);

        // 6: Realign_Req beats the 4th EIEOS beat; then mid-block realign while locked
        step("t6_rr", 1, 32'h1234, 2'b01, 1);
        for (int i = 0; i < 3; i++) step("t6_e", 1, EIE, (i == 0) ? 2'b10 : 2'b01, 0);
        step("t6_e4", 1, EIE, 2'b01, 1);
        chk("t6_not_aligned", Aligned, 1'b0);
        step("t6_after", 1, EIE, 2'b01, 0);
        eieos("t6_realign");
        for (int k = 0; k < LOCK_B; k++) block("t6_lock", 2'b10, 0);
        chk("t6_locked", Locked, 1'b1);
        step("t6_b0", 1, $urandom, 2'b01, 0);
        step("t6_b1", 1, $urandom, 2'b01, 0);
        step("t6_rr_mid", 1, $urandom, 2'b01, 1);
        chk("t6_dv0", RX_Data_Valid_Out, 1'b0);
        chk("t6_unlocked", Locked, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [1:0] sh;
            r = $urandom_range(0, 99);
            if (!m_aligned && r < 8) begin
                eieos("rnd_eieos");
            end else begin
                sh = ($urandom_range(0, 99) < 85) ? 2'($urandom_range(1, 2)) : 2'($urandom);
                step("rnd", $urandom_range(0, 99) < 75,
                     (r < 20) ? EIE : $urandom, sh, $urandom_range(0, 299) == 0);
            end
        end

        // Asynchronous reset mid-block
        eieos("ar_eieos");
        block("ar_blk", 2'b10, 0);
        step("ar_b0", 1, $urandom, 2'b10, 0);
        RST_L = 0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge CLK); #1;
        RST_L = 1;
        step("ar_post", 1, $urandom, 2'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_block_align_ctrl.md
Name: rx_block_align_ctrl

Overview:
Sequences the RX 128b/130b block datapath for one lane. It acquires block alignment by finding an EIEOS, then generates the start-of-block strobe, beat index and block-type decode for downstream RX logic. It monitors sync-header integrity and reports alignment and lock status to the LTSSM. It sits between the per-lane gearbox output and the second-half RX block/ordered-set handling.

Parameters:
ERR_THRESH, 4, number of consecutive invalid sync headers that drops alignment (range 1..15).
LOCK_BLOCKS, 8, number of consecutive valid sync headers needed to go from ALIGNED to LOCKED (range 1..15).

Ports:
CLK  in  1  clock
RST_L  in  1  reset, asynchronous, active-low
RX_Valid  in  1  one 32-bit beat (4 symbols, symbol 0 in bits [7:0]) present this cycle
RX_Data  in  32  beat data
RX_Sync_Header  in  [0:1]  sync header; meaningful on the beat treated as block start
Realign_Req  in  1  LTSSM request to drop alignment and re-search
RX_Data_Out  out  32  registered copy of RX_Data
RX_Data_Valid_Out  out  1  beat belongs to an aligned block
RX_Start_Block  out  1  first beat of a block (beat index 0)
RX_Beat_Idx  out  2  beat index 0..3 within the block
Block_Type  out  1  0 = data block, 1 = ordered-set block; held for the whole block
Sync_Err  out  1  one-cycle pulse when a block carries an invalid header (00 or 11)
Aligned  out  1  state is ALIGNED or LOCKED
Locked  out  1  state is LOCKED

Behaviour:
- Reset: state UNALIGNED; all counters 0; every output 0.
- All outputs are registered, with 1-cycle latency from the input beat.
- States: UNALIGNED, ALIGNED, LOCKED. A block is 4 valid beats.
- When RX_Valid = 0: counters and state hold; RX_Data_Valid_Out, RX_Start_Block and Sync_Err are 0; Block_Type holds.
- UNALIGNED search:
  - Candidate start = a valid beat with header 2'b10 and data 32'hFF00FF00.
  - Each following valid beat that equals 32'hFF00FF00 increments match_cnt.
  - Any mismatch resets match_cnt to 0, or to 1 if that beat is itself a candidate start.
  - The 4th matching beat moves the state to ALIGNED. The next valid beat is beat 0.
  - While UNALIGNED, RX_Data_Valid_Out = 0.
- ALIGNED/LOCKED:
  - beat_cnt increments on each valid beat, wrapping 3 -> 0.
  - RX_Start_Block = 1 on beat 0, and RX_Data_Valid_Out = 1 on every valid beat.
- Header decode at beat 0:
  - 01 -> Block_Type 0.
  - 10 -> Block_Type 1.
  - 00 or 11 -> Block_Type 0 and Sync_Err pulse.
  - Block_Type is latched at beat 0 and held through beats 1..3.
- Valid header: bad_cnt = 0; good_cnt increments, saturating at LOCK_BLOCKS. When good_cnt reaches LOCK_BLOCKS in ALIGNED, the state moves to LOCKED on that block.
- Invalid header: good_cnt = 0; bad_cnt increments. When bad_cnt reaches ERR_THRESH, the state moves to UNALIGNED from either ALIGNED or LOCKED, and all counters clear.
  - The failing block's beat 0 is still output with Sync_Err = 1.
  - From the next beat on, RX_Data_Valid_Out = 0.
- LOCKED stays LOCKED on isolated bad headers below the threshold.
- Realign_Req has the highest priority: the next state is UNALIGNED and all counters clear. It wins over a simultaneous 4th EIEOS match or block boundary. RX_Data_Valid_Out is 0 from the following cycle.
- Once aligned, an EIEOS arriving at beat 0 is treated as a normal ordered-set block; there is no phase re-check.
- Reset mid-block clears everything immediately and asynchronously.

Decomposition:
- Package rx_block_pkg holds:
  - align_state_t enum {UNALIGNED, ALIGNED, LOCKED}
  - SH_DATA = 2'b01, SH_OS = 2'b10
  - EIEOS_BEAT = 32'hFF00FF00
  - BEATS_PER_BLOCK = 4
- Sub-module rx_eieos_detector contains match_cnt and the candidate-start logic, and outputs a one-cycle found pulse. The FSM, beat counter, header checker and output registers remain in the top module.

Test Plan:
1. Reset, then 4 beats FF00FF00 with header 10 on the first -> Aligned = 1 one cycle after the 4th beat; the next valid beat gives RX_Start_Block = 1 and RX_Beat_Idx = 0.
2. Aligned, block with header 01 then block with header 10, with RX_Valid gaps inserted -> Block_Type 0 for 4 beats, then 1 for 4 beats; gaps give Valid_Out = 0 and the index holds.
3. 8 consecutive valid blocks -> Locked = 1 on the 8th block's beat 0 output.
4. Locked, headers 11, 00, 11, 00 on 4 consecutive blocks -> 4 Sync_Err pulses; Aligned = 0 after the 4th; one valid header between them resets bad_cnt and keeps lock.
5. Partial EIEOS (3 matching beats, then 00000000) -> stays UNALIGNED, match_cnt = 0; a following full EIEOS aligns.
6. Realign_Req asserted in the same cycle as the 4th EIEOS beat -> stays UNALIGNED, Aligned = 0; Realign_Req while Locked mid-block -> Valid_Out = 0 next cycle.
